// File: rtl/rsa_prime_pair_gen.sv
// rsa_prime_pair_gen: searches for two distinct odd probable primes p and q for RSA key
// generation by sequencing a shared external Miller-Rabin tester.
//
// Candidates start at the seed with the MSB and LSB forced to 1 and advance by 2. When
// the step overflows, the search wraps to 2^MBIT+1. The q search continues from the
// candidate after p, so q differs from p.
//
// Optional build macro: PRIME_GEN_SMALLDIV_EN. When it is defined, candidates divisible
// by 3, 5 or 7 are rejected locally in one cycle and are never sent to the tester. The
// p, q, tries and fail results are the same in both builds.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   start, seed   begin a search (accepted in idle only); starting candidate
//   busy, done    search in progress (through the done cycle); one-cycle end pulse
//   fail          budget of MAX_TRIES candidates exhausted (valid with done, held)
//   p, q          result primes (valid with done when fail=0, held)
//   tries         candidates consumed in the current or last search
//   test_n        candidate presented to the tester, stable from issue through check
//   test_start    one-cycle tester issue strobe
//   test_busy     tester busy flag
//   test_isprime  tester verdict, valid once test_busy falls
module rsa_prime_pair_gen #(
  parameter int unsigned MBIT      = 63,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MBIT:0] seed,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [MBIT:0] p,
  output logic [MBIT:0] q,
  output logic [15:0]   tries,
  output logic [MBIT:0] test_n,
  output logic          test_start,
  input  logic          test_busy,
  input  logic          test_isprime
);

  localparam logic [MBIT:0] CandBase = {1'b1, {(MBIT - 1){1'b0}}, 1'b1};
  localparam logic [MBIT:0] CandStep = {{(MBIT - 1){1'b0}}, 2'b10};
  localparam logic [15:0]   MaxTries = 16'(MAX_TRIES);

  typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StCheck, StDone} state_e;

  state_e        state_q, state_d;
  logic [MBIT:0] cand_q, cand_d;
  logic [MBIT:0] p_q, p_d;
  logic [MBIT:0] q_q, q_d;
  logic [15:0]   tries_q, tries_d;
  logic          fail_q, fail_d;
  logic          phase_q, phase_d;  // 0: searching for p, 1: searching for q
  logic          small_div;

  // Next odd candidate; an overflow that clears the MSB restarts at 2^MBIT+1.
  function automatic logic [MBIT:0] advance(input logic [MBIT:0] c);
    logic [MBIT:0] n;
    n = c + CandStep;
    if (!n[MBIT]) n = CandBase;
    return n;
  endfunction

`ifdef PRIME_GEN_SMALLDIV_EN
  localparam logic [MBIT:0] Div3 = {{(MBIT - 1){1'b0}}, 2'd3};
  localparam logic [MBIT:0] Div5 = {{(MBIT - 2){1'b0}}, 3'd5};
  localparam logic [MBIT:0] Div7 = {{(MBIT - 2){1'b0}}, 3'd7};
  assign small_div = ((cand_q % Div3) == '0) || ((cand_q % Div5) == '0) ||
                     ((cand_q % Div7) == '0);
`else
  assign small_div = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cand_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      tries_q <= '0;
      fail_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      p_q     <= p_d;
      q_q     <= q_d;
      tries_q <= tries_d;
      fail_q  <= fail_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    p_d        = p_q;
    q_d        = q_q;
    tries_d    = tries_q;
    fail_d     = fail_q;
    phase_d    = phase_q;
    test_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          cand_d  = seed | CandBase;
          p_d     = '0;
          q_d     = '0;
          tries_d = '0;
          fail_d  = 1'b0;
          phase_d = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Budget is checked before issue so the tester never starts on an exhausted budget.
        if (tries_q == MaxTries) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end else if (small_div) begin
          tries_d = tries_q + 16'd1;
          cand_d  = advance(cand_q);
        end else begin
          test_start = 1'b1;
          tries_d    = tries_q + 16'd1;
          state_d    = StArm;
        end
      end
      StArm: begin
        if (test_busy) state_d = StWait;
      end
      StWait: begin
        if (!test_busy) state_d = StCheck;
      end
      StCheck: begin
        if (test_isprime && phase_q) begin
          q_d     = cand_q;
          state_d = StDone;
        end else begin
          if (test_isprime) begin
            p_d     = cand_q;
            phase_d = 1'b1;
          end
          cand_d  = advance(cand_q);
          state_d = StIssue;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign fail   = fail_q;
  assign p      = p_q;
  assign q      = q_q;
  assign tries  = tries_q;
  assign test_n = (state_q inside {StIssue, StArm, StWait, StCheck}) ? cand_q : '0;

endmodule

// File: doc/rsa_prime_pair_gen.md
# rsa_prime_pair_gen

Controller that searches for two distinct probable primes p and q for RSA key generation. It sequences an external Miller-Rabin prime tester: it generates odd candidates from a seed, issues each one to the tester, and collects the verdicts. It sits between the key-generation top level and the single shared prime-test instance, and owns the tester's request interface while busy.

## Interface
- MBIT, 63: operand MSB index; operand width W = MBIT+1; MBIT ≥ 3 required.
- MAX_TRIES, 1024: total candidate budget across the p and q searches.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin search; sampled in IDLE only.
- seed  in  W  starting candidate; captured on accepted start.
- busy  out  1  high from accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse at end of search.
- fail  out  1  valid with done; 1 means the budget was exhausted. Held until the next accepted start.
- p, q  out  W  result primes; valid when done=1 and fail=0. Held until the next accepted start.
- tries  out  16  candidates consumed in the current or last search.
- test_n  out  W  candidate presented to the tester.
- test_start  out  1  one-cycle issue strobe.
- test_busy  in  1  tester busy flag.
- test_isprime  in  1  tester verdict; valid once test_busy falls.

## Operation
- States: IDLE, ISSUE, ARM, WAIT, CHECK, DONE.
- IDLE:
  - On start=1, capture seed into cand with bit MBIT and bit 0 forced to 1.
  - Clear tries, p, q and fail; set phase=P; go to ISSUE.
- ISSUE:
  - If tries == MAX_TRIES, set fail=1 and go to DONE.
  - Otherwise drive test_n=cand, pulse test_start, increment tries, and go to ARM.
- ARM: wait for test_busy=1, then go to WAIT.
- WAIT: wait for test_busy=0, then go to CHECK.
- test_n must stay stable from ISSUE through CHECK.
- CHECK:
  - If test_isprime=1 and phase=P: p←cand, phase←Q.
  - If test_isprime=1 and phase=Q: q←cand, go to DONE.
  - Otherwise (composite, or a prime that completed the p phase), advance cand and return to ISSUE.
- Advance: cand←cand+2 modulo 2^W. If the result has bit MBIT=0 (wrap), cand←2^MBIT+1. The q search therefore resumes from p+2, so q≠p by construction.
- DONE: pulse done with busy=1, then return to IDLE.
- start is ignored when not in IDLE.
- Reset, including mid-search, returns the block to IDLE: all outputs 0, test_start 0, and any in-flight tester result is discarded.

## Timing
- Reset values: busy, done, fail, p, q, tries, test_n and test_start are all 0.
- start accepted at edge k gives busy=1 from k+1.
- Per tested candidate: 1 cycle ISSUE, plus the tester's response time, plus 1 cycle CHECK. Minimum 4 cycles with a tester whose busy lasts 1 cycle.
- done is asserted exactly one cycle after the CHECK or ISSUE cycle that terminated the search. busy drops the cycle after done.
- p is updated in the CHECK cycle where it is found; q and done follow later.
- tries saturates at MAX_TRIES; the check happens before issue, so the tester is never started with the budget exhausted.

## Configuration
- PRIME_GEN_SMALLDIV_EN defined:
  - ISSUE first runs a combinational trial division of cand by 3, 5 and 7.
  - If any remainder is 0: increment tries, advance cand, stay in ISSUE, and do not pulse test_start. This costs 1 cycle per rejected candidate.
- Undefined: every candidate goes to the tester.
- p, q, tries and fail results are identical in both builds; only the tester issue count and latency differ.

## Test plan
All scenarios use MBIT=7 and a behavioral tester (exact primality, 3-cycle busy).

- seed=0x80, start pulse -> p=131, q=137, tries=5, fail=0, done pulses once; tester issued 5 times (2 with PRIME_GEN_SMALLDIV_EN).
- seed=0xFA -> p=251; q search goes 253, 255, wraps to 129, then 131 -> q=131, tries=5.
- MAX_TRIES=3, seed=0x80 -> p=131, done with fail=1, tries=3, q=0.
- start pulsed again while busy -> ignored; results match a single run.
- rst asserted in WAIT mid-search -> all outputs 0 immediately. A new start with seed=0x80 then completes normally with p=131, q=137.
- Tester holds busy high for 50 cycles -> test_n stays stable throughout; the controller samples test_isprime only after busy falls.
